gray_decode_scheduler: RTL
==========================

// Module: gray_decode_scheduler
// PURPOSE
//   Shares one 4-bit Gray-to-binary decode path between N_REQ requesters.
//   - Round-robin arbitration, valid/ready handshake on each input and on the output.
//   - Each accepted code is decoded and held in a single registered output stage,
//     tagged with the requester index.
//   - Sits between the Gray-coded sources (counters, encoders, CDC pointers)
//     and the binary consumers.
// PARAMETERS
//   N_REQ   4   number of requesters (>=1)
//   ID_W    (N_REQ>1 ? $clog2(N_REQ) : 1)   requester-index width (derived, do not override)
// PORTS
//   clk          in   1           rising-edge clock
//   rst_n        in   1           synchronous reset, active-low
//   req_valid    in   N_REQ       requester i presents a Gray code
//   req_gray     in   4*N_REQ     code of requester i at [4*i+3:4*i]
//   req_ready    out  N_REQ       one-hot/zero: requester i accepted this cycle
//   out_valid    out  1           out_binary/out_id hold a decoded result
//   out_ready    in   1           consumer takes result when out_valid && out_ready
//   out_binary   out  4           decoded binary value
//   out_id       out  ID_W        index of requester that supplied it
//   busy         out  1           out_valid || |req_valid
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge): out_valid=0, out_binary=0, out_id=0, rr_ptr=N_REQ-1.
//     The first grant after reset goes to the lowest-index valid requester.
//     Any held result is discarded.
//   - Output slot state:
//     EMPTY (out_valid=0) / FULL (out_valid=1).
//     can_accept = !out_valid || out_ready.
//   - Grant (combinational):
//     - When can_accept, grant the first valid requester searching rr_ptr+1, rr_ptr+2, ... with wrap modulo N_REQ.
//     - req_ready[g]=1 for that requester only; all other bits are 0.
//     - req_ready may depend on req_valid.
//     - Requesters must not make req_ready a condition of asserting req_valid.
//   - Transfer on posedge when req_valid[g] && req_ready[g]:
//     - out_binary <= gray-to-binary(req_gray[g]); out_id <= g; out_valid <= 1; rr_ptr <= g.
//     - Decode rule: b3=g3, bi = b(i+1) ^ gi.
//   - Output drain: on out_valid && out_ready with no new grant, out_valid <= 0.
//   - Simultaneous drain + grant: the slot reloads in the same cycle and out_valid stays 1.
//     Full throughput is 1 result per clock.
//   - Stall (out_valid && !out_ready):
//     - req_ready=0.
//     - out_binary/out_id/out_valid are held stable.
//     - rr_ptr does not move.
//   - Latency: 1 clock from accepting edge to out_valid.
//   - Fairness: a continuously valid requester is granted within N_REQ grants.
//   - No valid requesters: no grant, rr_ptr unchanged.
//   - N_REQ=1: arbiter degenerates to pass-through with registered output; out_id=0.
//   - req_gray of non-granted requesters is ignored; X on them must not propagate.
// STRUCTURE
//   - gray_pkg: localparam GRAY_W=4; typedef logic [GRAY_W-1:0] gray_t, bin_t;
//     function gray2bin(gray_t).
//   - Sub-module gray_rr_arbiter (req, ptr, en -> one-hot grant, grant index).
//   - Decode is done by the team's existing gray_decoder, instantiated once on the muxed code.
//   - Output slot register and rr_ptr register live in this module.
// TESTING
//   1. Reset:
//      - Stimulus: rst_n=0 with all req_valid=1.
//      - Required: out_valid=0, req_ready=0. After release, first grant to req 0.
//   2. Single request:
//      - Stimulus: req 2 valid, gray=4'b1011, out_ready=1.
//      - Required: next cycle out_binary=4'b1101, out_id=2, out_valid=1 for 1 cycle.
//   3. Round robin:
//      - Stimulus: all 4 valid, out_ready=1.
//      - Required: out_id sequence 0,1,2,3,0,... one result per clock.
//   4. Backpressure:
//      - Stimulus: out_ready=0 for 5 cycles after first result.
//      - Required: output held stable, req_ready=0. On release, next id continues the rotation.
//   5. Exhaustive decode: all 16 Gray codes on req 0 -> binary matches gray2bin for each.
//   6. Reset mid-stall:
//      - Stimulus: out_valid=1, out_ready=0, assert rst_n=0.
//      - Required: out_valid=0 next edge, result dropped, rr_ptr back to N_REQ-1.

Source files
------------

// File: rtl/gray_pkg.sv
// Purpose: shared Gray-code widths, types and the reference Gray-to-binary decode function.
// Latency: n/a (types and a pure combinational function).
// Backpressure: n/a.
package gray_pkg;

  localparam int GRAY_W = 4;

  typedef logic [GRAY_W-1:0] gray_t;
  typedef logic [GRAY_W-1:0] bin_t;

  // MSB passes straight through; each lower bit is the running XOR from the top.
  function automatic bin_t gray2bin(input gray_t g);
    bin_t b;
    b[GRAY_W-1] = g[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_decoder.sv
// Purpose: combinational 4-bit Gray-to-binary decoder.
// Latency: 0 clocks (pure combinational).
// Backpressure: none; output follows input.
module gray_decoder
  import gray_pkg::*;
(
  input  gray_t gray,
  output bin_t  binary
);

  assign binary = gray2bin(gray);

endmodule

// File: rtl/gray_rr_arbiter.sv
// Purpose: round-robin arbiter; searches ptr+1, ptr+2, ... (mod N_REQ) for the first active request.
// Latency: 0 clocks (combinational grant).
// Backpressure: en=0 suppresses every grant.
module gray_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_any
);

  logic [ID_W-1:0] idx;

  // Walk the requesters in rotation order starting just after the last winner.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = ID_W'((int'(ptr) + off) % N_REQ);
      if (en && !grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_decode_scheduler.sv
// Purpose: shares one Gray-to-binary decoder among N_REQ requesters with round-robin arbitration.
// Latency: 1 clock from the accepting edge to out_valid; one result per clock at full rate.
// Backpressure: out_valid && !out_ready holds the output slot and drops every req_ready.
module gray_decode_scheduler
  import gray_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [4*N_REQ-1:0]    req_gray,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [GRAY_W-1:0]     out_binary,
  output logic [ID_W-1:0]       out_id,
  output logic                  busy
);

  logic [ID_W-1:0]  rr_ptr;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic             can_accept;
  gray_t            sel_gray;
  bin_t             sel_bin;

  // No handshakes while reset is held so nothing is acknowledged that will be discarded.
  assign can_accept = rst_n && (!out_valid || out_ready);
  assign req_ready  = grant;
  assign busy       = out_valid || (|req_valid);

  gray_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  // AND-OR style mux keyed on the one-hot grant so non-granted lanes (even X) never reach the decoder.
  always_comb begin
    sel_gray = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_gray = req_gray[GRAY_W*i +: GRAY_W];
      end
    end
  end

  gray_decoder u_dec (
    .gray   (sel_gray),
    .binary (sel_bin)
  );

  // Output slot and rotation pointer: reload on grant, drain on consume, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_binary <= '0;
      out_id     <= '0;
      rr_ptr     <= ID_W'(N_REQ - 1);
    end else if (grant_any) begin
      out_valid  <= 1'b1;
      out_binary <= sel_bin;
      out_id     <= grant_idx;
      rr_ptr     <= grant_idx;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
